// File: rtl/seg7_scan_display_if.sv
// Digit/segment bundle between the BCD counter side and the 7-segment scanner.
// The scanner consumes digits_n/dp_n and drives the segment/anode pins.
interface seg7_scan_display_if;
  logic [15:0] digits_n;
  logic [3:0]  dp_n;
  logic [7:0]  seg;
  logic [3:0]  sel;

  modport master (output digits_n, output dp_n, input seg, input sel);
  modport slave  (input digits_n, input dp_n, output seg, output sel);
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for active-low BCD digits,
// with an anti-ghost blank gap between digits and optional leading-zero blanking.
module seg7_scan_display #(
  parameter int SCAN_MAX  = 6000,
  parameter int BLANK_CYC = 60,
  parameter int LZB       = 1
) (
  input  logic clk,
  input  logic reset,
  seg7_scan_display_if.slave bus
);

  typedef enum logic {BLANK, SHOW} state_t;

  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYC - 1);
  localparam logic [15:0] SHOW_LAST  = 16'(SCAN_MAX - 1);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [1:0]  idx, idx_next;
  logic [7:0]  seg_q, seg_next;
  logic [3:0]  sel_q, sel_next;

  logic [3:0]  val [4];
  logic [3:0]  blank_lz;
  logic [6:0]  digit_code;
  logic        digit_dp;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // A digit blanks only if it and everything above it are zero; '-' codes are non-zero.
  always_comb begin
    for (int i = 0; i < 4; i++) val[i] = ~bus.digits_n[4*i +: 4];
    blank_lz    = 4'b0000;
    blank_lz[3] = (LZB != 0) && (val[3] == 4'd0);
    blank_lz[2] = blank_lz[3] && (val[2] == 4'd0);
    blank_lz[1] = blank_lz[2] && (val[1] == 4'd0);
    digit_code  = blank_lz[idx] ? 7'h7F : decode(val[idx]);
    digit_dp    = bus.dp_n[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BLANK;
      cnt   <= 16'd0;
      idx   <= 2'd0;
      seg_q <= 8'hFF;
      sel_q <= 4'hF;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      seg_q <= seg_next;
      sel_q <= sel_next;
    end
  end

  // Inputs are latched only on the BLANK->SHOW edge so SEG stays stable for the whole slot.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 16'd1;
    idx_next   = idx;
    seg_next   = seg_q;
    sel_next   = sel_q;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_next = SHOW;
          cnt_next   = 16'd0;
          sel_next   = ~(4'b0001 << idx);
          seg_next   = {digit_dp, digit_code};
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_next = BLANK;
          cnt_next   = 16'd0;
          idx_next   = idx + 2'd1;
          sel_next   = 4'hF;
          seg_next   = 8'hFF;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  assign bus.seg = seg_q;
  assign bus.sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: one instance with leading-zero blanking,
// one without, both fed the same digits and checked every cycle.
module tb_seg7_scan_display;

  localparam int SCAN_MAX  = 8;
  localparam int BLANK_CYC = 2;
  localparam int PERIOD    = SCAN_MAX + BLANK_CYC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits_n = 16'hFFFF;
  logic [3:0]  dp_n = 4'hF;

  int vector_count = 0;
  int miss_count   = 0;
  int edge_cnt     = 0;

  logic [7:0] q_lzb[$];
  logic [7:0] q_full[$];

  logic [6:0] seg_table [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  seg7_scan_display_if if_lzb ();
  seg7_scan_display_if if_full ();

  assign if_lzb.digits_n  = digits_n;
  assign if_lzb.dp_n      = dp_n;
  assign if_full.digits_n = digits_n;
  assign if_full.dp_n     = dp_n;

  seg7_scan_display #(.SCAN_MAX(SCAN_MAX), .BLANK_CYC(BLANK_CYC), .LZB(1)) dut_lzb (
    .clk(clk), .reset(reset), .bus(if_lzb.slave));

  seg7_scan_display #(.SCAN_MAX(SCAN_MAX), .BLANK_CYC(BLANK_CYC), .LZB(0)) dut_full (
    .clk(clk), .reset(reset), .bus(if_full.slave));

  always #5 clk = ~clk;

  initial begin
    assert (SCAN_MAX >= 2 && SCAN_MAX <= 65535) else $error("[TB] SCAN_MAX out of range");
    assert (BLANK_CYC >= 1 && BLANK_CYC <= 255) else $error("[TB] BLANK_CYC out of range");
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vector_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference segment pattern for one digit slot, computed straight from the display rules.
  function automatic logic [7:0] exp_seg(input logic [15:0] dn, input logic [3:0] dpn,
                                         input int slot, input bit lzb);
    logic [3:0] v;
    bit blank;
    v = ~dn[slot*4 +: 4];
    blank = lzb && (slot != 0);
    for (int j = slot; j < 4; j++)
      if ((~dn[j*4 +: 4]) != 4'd0) blank = 1'b0;
    return {dpn[slot], blank ? 7'h7F : seg_table[v]};
  endfunction

  function automatic bit in_show(input int e);
    return (e >= BLANK_CYC) && (((e - BLANK_CYC) % PERIOD) < SCAN_MAX);
  endfunction

  function automatic logic [3:0] exp_sel(input int e);
    return in_show(e) ? ~(4'b0001 << (((e - BLANK_CYC) / PERIOD) % 4)) : 4'hF;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      edge_cnt <= 0;
      q_lzb.delete();
      q_full.delete();
    end else begin
      edge_cnt <= edge_cnt + 1;
      if ((edge_cnt + 1 >= BLANK_CYC) && (((edge_cnt + 1 - BLANK_CYC) % PERIOD) == 0)) begin
        q_lzb.push_back(exp_seg(digits_n, dp_n, ((edge_cnt + 1 - BLANK_CYC) / PERIOD) % 4, 1'b1));
        q_full.push_back(exp_seg(digits_n, dp_n, ((edge_cnt + 1 - BLANK_CYC) / PERIOD) % 4, 1'b0));
      end
    end
  end

  // Every cycle: blank slots must be fully dark, show slots must hold the queued code.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("reset_sel", {4'h0, if_lzb.sel}, 8'h0F);
      checkOutput("reset_seg", if_lzb.seg, 8'hFF);
    end else if (edge_cnt >= 1) begin
      checkOutput($sformatf("sel_lzb@%0d", edge_cnt), {4'h0, if_lzb.sel}, {4'h0, exp_sel(edge_cnt)});
      checkOutput($sformatf("sel_full@%0d", edge_cnt), {4'h0, if_full.sel}, {4'h0, exp_sel(edge_cnt)});
      if (in_show(edge_cnt)) begin
        checkOutput($sformatf("seg_lzb@%0d", edge_cnt), if_lzb.seg,
                    (q_lzb.size() > 0) ? q_lzb[0] : 8'hXX);
        checkOutput($sformatf("seg_full@%0d", edge_cnt), if_full.seg,
                    (q_full.size() > 0) ? q_full[0] : 8'hXX);
        if (((edge_cnt - BLANK_CYC) % PERIOD) == SCAN_MAX - 1) begin
          if (q_lzb.size() > 0) void'(q_lzb.pop_front());
          if (q_full.size() > 0) void'(q_full.pop_front());
        end
      end else begin
        checkOutput($sformatf("seg_lzb@%0d", edge_cnt), if_lzb.seg, 8'hFF);
        checkOutput($sformatf("seg_full@%0d", edge_cnt), if_full.seg, 8'hFF);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] dn, input logic [3:0] dpn, input int cycles);
    digits_n = dn;
    dp_n     = dpn;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    bit found;
    reset    = 1'b0;
    digits_n = ~16'h1234;
    dp_n     = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    applyStimulus(~16'h1234, 4'hF, 87);
    applyStimulus(~16'h5678, 4'hF, 80);

    for (int v = 0; v < 16; v++)
      applyStimulus(~{12'h111, 4'(v)}, 4'hF, 4 * PERIOD);

    applyStimulus(~16'h0050, 4'hF, 4 * PERIOD);
    applyStimulus(~16'h0000, 4'hF, 4 * PERIOD);
    applyStimulus(~16'h1234, 4'hB, 4 * PERIOD);
    applyStimulus(~16'h0050, 4'hB, 4 * PERIOD);
    applyStimulus(~16'hA9F0, 4'h6, 4 * PERIOD);

    // Hit the reset while digit3 is lit, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 6 * PERIOD && !found; i++) begin
      @(negedge clk);
      if (if_lzb.sel == 4'h7) found = 1'b1;
    end
    checkOutput("find_digit3", {7'h0, found}, 8'h01);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_sel", {4'h0, if_lzb.sel}, 8'h0F);
    checkOutput("async_seg", if_lzb.seg, 8'hFF);
    checkOutput("async_sel_full", {4'h0, if_full.sel}, 8'h0F);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(~16'h0908, 4'hE, 6 * PERIOD);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
